// File: rtl/button_event_conditioner.sv
// ---------------------------------------------------------------------------
// button_event_conditioner
//
// Front end for the click/action encoder. Each of the five raw board buttons
// is synchronised (2 flops) and debounced. A debounced 0->1 transition is a
// one-cycle press pulse. Centre presses go through a small IDLE/WINDOW FSM
// that classifies them as single or double clicks. At most one event is held
// on the encoder lines until ACK is sampled high.
//
// Ports:
//   clk                 system clock
//   clear_n             asynchronous active-low reset
//   btn{C,U,R,D,L}_raw  raw, asynchronous, bouncing buttons (active high)
//   ACK                 encoder has consumed the held event
//   inbtnC              single centre click held
//   indblbtnC           double centre click held
//   inU/inR/inD/inL     directional press held
//   evt_valid           OR of the six event outputs
// ---------------------------------------------------------------------------
module button_event_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int DBL_WINDOW_CYCLES = 25000000,
    parameter int CNT_W             = 25
) (
    input  logic clk,
    input  logic clear_n,
    input  logic btnC_raw,
    input  logic btnU_raw,
    input  logic btnR_raw,
    input  logic btnD_raw,
    input  logic btnL_raw,
    input  logic ACK,
    output logic inbtnC,
    output logic indblbtnC,
    output logic inU,
    output logic inR,
    output logic inD,
    output logic inL,
    output logic evt_valid
);

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(DBL_WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Press vector bit order: 0=C, 1=U, 2=R, 3=D, 4=L
    localparam int B_C = 0;
    localparam int B_U = 1;
    localparam int B_R = 2;
    localparam int B_D = 3;
    localparam int B_L = 4;

    // Held-event bit order
    localparam int EV_C   = 0;
    localparam int EV_DBL = 1;
    localparam int EV_U   = 2;
    localparam int EV_R   = 3;
    localparam int EV_D   = 4;
    localparam int EV_L   = 5;

    typedef enum logic {
        IDLE,
        WINDOW
    } state_t;

    logic [4:0] raw_vec;
    logic [4:0] press;

    assign raw_vec = {btnL_raw, btnD_raw, btnR_raw, btnU_raw, btnC_raw};

    // -----------------------------------------------------------------------
    // Per-button synchroniser + debouncer
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_btn
            logic             sync1_reg;
            logic             sync2_reg;
            logic             level_reg;
            logic             press_reg;
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge clear_n) begin
                if (!clear_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    press_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= raw_vec[gi];
                    sync2_reg <= sync1_reg;
                    press_reg <= 1'b0;
                    if (sync2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg >= DB_LAST) begin
                        // This is the DEBOUNCE_CYCLES-th consecutive cycle of
                        // disagreement: accept the new level.
                        level_reg <= sync2_reg;
                        cnt_reg   <= '0;
                        press_reg <= sync2_reg;
                    end else if (cnt_reg != CNT_MAX) begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Centre FSM and held-event register
    // -----------------------------------------------------------------------
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] win_reg, win_next;
    logic [5:0]       evt_reg, evt_next;
    logic [5:0]       new_evt;
    logic             slot_free;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_reg <= IDLE;
            win_reg   <= '0;
            evt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            win_reg   <= win_next;
            evt_reg   <= evt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        win_next   = win_reg;
        new_evt    = '0;
        // The slot can take a new event if empty, or if ACK frees it this cycle.
        slot_free  = (evt_reg == '0) || ACK;

        case (state_reg)
            IDLE: begin
                win_next = '0;
                if (press[B_C]) begin
                    // Centre has top priority; any simultaneous direction is lost.
                    if (slot_free) begin
                        state_next = WINDOW;
                        win_next   = CNT_ONE;
                    end
                end else if (press[B_U]) begin
                    new_evt[EV_U] = 1'b1;
                end else if (press[B_R]) begin
                    new_evt[EV_R] = 1'b1;
                end else if (press[B_D]) begin
                    new_evt[EV_D] = 1'b1;
                end else if (press[B_L]) begin
                    new_evt[EV_L] = 1'b1;
                end
            end
            WINDOW: begin
                // Directions are ignored while a click is being classified.
                if (press[B_C]) begin
                    new_evt[EV_DBL] = 1'b1;
                    state_next      = IDLE;
                    win_next        = '0;
                end else if (win_reg >= WIN_LAST) begin
                    // Counter would reach DBL_WINDOW_CYCLES on this edge.
                    new_evt[EV_C] = 1'b1;
                    state_next    = IDLE;
                    win_next      = '0;
                end else if (win_reg != CNT_MAX) begin
                    win_next = win_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                win_next   = '0;
            end
        endcase

        if ((new_evt != '0) && slot_free) begin
            evt_next = new_evt;
        end else if (ACK) begin
            evt_next = '0;
        end else begin
            evt_next = evt_reg;
        end
    end

    assign inbtnC    = evt_reg[EV_C];
    assign indblbtnC = evt_reg[EV_DBL];
    assign inU       = evt_reg[EV_U];
    assign inR       = evt_reg[EV_R];
    assign inD       = evt_reg[EV_D];
    assign inL       = evt_reg[EV_L];
    assign evt_valid = |evt_reg;

endmodule

// File: tb/tb_button_event_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_event_conditioner
//
// Scoreboard bench: each stimulus pushes the expected event code and the edge
// at which it must appear; a negedge monitor pops and compares whenever the
// held event changes to a new non-zero code. Unexpected events fail.
// ---------------------------------------------------------------------------
module tb_button_event_conditioner;

    localparam int DB  = 4;
    localparam int WIN = 20;

    localparam logic [5:0] E_C   = 6'b000001;
    localparam logic [5:0] E_DBL = 6'b000010;
    localparam logic [5:0] E_U   = 6'b000100;
    localparam logic [5:0] E_R   = 6'b001000;
    localparam logic [5:0] E_D   = 6'b010000;
    localparam logic [5:0] E_L   = 6'b100000;

    logic       clk = 1'b0;
    logic       clear_n;
    logic [4:0] raw;      // 0=C 1=U 2=R 3=D 4=L
    logic       ACK;
    logic       inbtnC, indblbtnC, inU, inR, inD, inL, evt_valid;
    logic [5:0] evt_vec;
    logic [5:0] prev_evt = '0;

    int cyc    = 0;
    int n_test = 0;
    int n_fail = 0;

    typedef struct {
        logic [5:0] code;
        int         edge_n;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    button_event_conditioner #(
        .DEBOUNCE_CYCLES  (DB),
        .DBL_WINDOW_CYCLES(WIN),
        .CNT_W            (5)
    ) dut (
        .clk      (clk),
        .clear_n  (clear_n),
        .btnC_raw (raw[0]),
        .btnU_raw (raw[1]),
        .btnR_raw (raw[2]),
        .btnD_raw (raw[3]),
        .btnL_raw (raw[4]),
        .ACK      (ACK),
        .inbtnC   (inbtnC),
        .indblbtnC(indblbtnC),
        .inU      (inU),
        .inR      (inR),
        .inD      (inD),
        .inL      (inL),
        .evt_valid(evt_valid)
    );

    assign evt_vec = {inL, inD, inR, inU, indblbtnC, inbtnC};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_test++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_evt(input logic [5:0] code, input int edge_n);
        exp_t x;
        x.code   = code;
        x.edge_n = edge_n;
        sb.push_back(x);
    endtask

    task automatic ack_pulse();
        ACK = 1'b1;
        wait_cycles(1);
        ACK = 1'b0;
    endtask

    // Monitor: one line per observed event, compared against the scoreboard.
    always @(negedge clk) begin
        check("evt_valid_or", evt_valid, |evt_vec);
        if (evt_vec != prev_evt && evt_vec != '0) begin
            $display("[TB] edge %0d event code 0x%0h", cyc, evt_vec);
            if (sb.size() == 0) begin
                check("unexpected_evt", evt_vec, 0);
            end else begin
                e = sb.pop_front();
                check("evt_code", evt_vec, e.code);
                check("evt_edge", cyc, e.edge_n);
            end
        end
        prev_evt <= evt_vec;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- Reset with all buttons high ----
        clear_n = 1'b0;
        ACK     = 1'b0;
        raw     = 5'b11111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_outputs", evt_vec, 0);
        end
        clear_n = 1'b1;
        raw     = 5'b00010;              // only U stays high
        expect_evt(E_U, cyc + DB + 3);
        wait_cycles(10);
        check("u_held", inU, 1);
        ack_pulse();
        check("u_ack_clear", inU, 0);
        raw[1] = 1'b0;
        wait_cycles(8);

        // ---- Bounce on R ----
        for (int i = 0; i < 6; i++) begin
            raw[2] = (i % 2 == 0);
            wait_cycles(2);
        end
        raw[2] = 1'b1;
        expect_evt(E_R, cyc + DB + 3);
        wait_cycles(10);
        check("r_held", inR, 1);
        ack_pulse();
        check("r_ack_clear", inR, 0);
        raw[2] = 1'b0;
        wait_cycles(8);

        // ---- Single click: press pulse at c+6, inbtnC at c+6+WIN ----
        raw[0] = 1'b1;
        expect_evt(E_C, cyc + DB + 2 + WIN);
        wait_cycles(8);
        raw[0] = 1'b0;
        wait_cycles(22);
        check("single_c", inbtnC, 1);
        check("single_no_dbl", indblbtnC, 0);
        ack_pulse();
        wait_cycles(8);

        // ---- Double click: pulses 10 apart, dbl on edge after second ----
        raw[0] = 1'b1;
        expect_evt(E_DBL, cyc + DB + 2 + 10 + 1);
        wait_cycles(5);
        raw[0] = 1'b0;
        wait_cycles(5);
        raw[0] = 1'b1;
        wait_cycles(8);
        raw[0] = 1'b0;
        wait_cycles(20);
        check("double_dbl", indblbtnC, 1);
        check("double_no_c", inbtnC, 0);
        ack_pulse();
        wait_cycles(8);

        // ---- Hold and drop ----
        raw[1] = 1'b1;
        expect_evt(E_U, cyc + DB + 3);
        wait_cycles(10);
        raw[1] = 1'b0;
        raw[4] = 1'b1;
        wait_cycles(8);
        raw[4] = 1'b0;
        wait_cycles(8);
        check("hold_u", inU, 1);
        check("drop_l", inL, 0);
        ack_pulse();
        raw[3] = 1'b1;
        expect_evt(E_D, cyc + DB + 3);
        wait_cycles(10);
        check("d_after_ack", inD, 1);
        raw[3] = 1'b0;
        ack_pulse();
        wait_cycles(8);

        // ---- ACK collides with a D press pulse while U is held ----
        raw[1] = 1'b1;
        expect_evt(E_U, cyc + DB + 3);
        wait_cycles(10);
        raw[1] = 1'b0;
        wait_cycles(8);
        raw[3] = 1'b1;
        expect_evt(E_D, cyc + DB + 3);
        wait_cycles(DB + 2);             // press pulse now high, sampled next edge
        ACK = 1'b1;
        wait_cycles(1);
        ACK = 1'b0;
        check("coll_u_clear", inU, 0);
        check("coll_d_load", inD, 1);
        check("coll_valid", evt_valid, 1);
        raw[3] = 1'b0;
        wait_cycles(8);
        ack_pulse();
        wait_cycles(4);

        // ---- C and U rise together: C wins, U dropped ----
        raw[0] = 1'b1;
        raw[1] = 1'b1;
        expect_evt(E_C, cyc + DB + 2 + WIN);
        wait_cycles(8);
        raw[0] = 1'b0;
        raw[1] = 1'b0;
        wait_cycles(22);
        check("cu_c_single", inbtnC, 1);
        check("cu_u_dropped", inU, 0);
        ack_pulse();
        wait_cycles(8);

        // ---- Reset mid-window drops the pending click ----
        raw[0] = 1'b1;
        wait_cycles(8);
        raw[0] = 1'b0;
        wait_cycles(7);
        clear_n = 1'b0;
        wait_cycles(2);
        check("midwin_rst_out", evt_vec, 0);
        clear_n = 1'b1;
        wait_cycles(40);
        check("midwin_no_evt", evt_vec, 0);
        raw[4] = 1'b1;
        expect_evt(E_L, cyc + DB + 3);
        wait_cycles(10);
        check("l_after_rst", inL, 1);
        raw[4] = 1'b0;
        ack_pulse();
        wait_cycles(8);

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

endmodule
